// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-unit results queue in a FIFO.
// Optional WB_ARB_STATS_EN adds saturating commit/stall/kill counters.
`ifndef ASIZE
`define ASIZE 5
`endif
`ifndef DSIZE
`define DSIZE 32
`endif
`ifndef ISIZE
`define ISIZE 32
`endif

module rf_write_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned LINK_REG     = 31
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_wen,
    input  logic [`ASIZE-1:0]   wb_addr,
    input  logic [`DSIZE-1:0]   wb_data,
    input  logic                wb_jal,
    input  logic [`ISIZE-1:0]   wb_pc,
    input  logic                lu_valid,
    input  logic [`ASIZE-1:0]   lu_addr,
    input  logic [`DSIZE-1:0]   lu_data,
    output logic                lu_ready,
    output logic                stall_req,
    output logic                rf_wen,
    output logic [`ASIZE-1:0]   rf_waddr,
    output logic [`DSIZE-1:0]   rf_wdata
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]         stat_lu_writes,
    output logic [15:0]         stat_stalls,
    output logic [15:0]         stat_kills
`endif
);

    localparam int unsigned AW = `ASIZE;
    localparam int unsigned DW = `DSIZE;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0]    q_addr [DEPTH];
    logic [DW-1:0]    q_data [DEPTH];
    logic [DEPTH-1:0] q_kill;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [3:0]       wait_cnt;

    logic             non_empty;
    logic             pipe_req;
    logic [AW-1:0]    pipe_addr;
    logic [DW-1:0]    pipe_data;
    logic             grant_pipe;
    logic             grant_fifo;
    logic             push;
    logic [AW-1:0]    head_addr;
    logic [DW-1:0]    head_data;
    logic             head_kill;
    logic [DEPTH-1:0] kill_hit;
    logic [PW-1:0]    offset;

    assign non_empty  = (count != '0);
    assign lu_ready   = (count != CW'(DEPTH));
    assign stall_req  = non_empty && (wait_cnt == 4'(STARVE_LIMIT));

    assign pipe_req   = wb_wen || wb_jal;
    assign pipe_addr  = wb_jal ? AW'(LINK_REG) : wb_addr;
    assign pipe_data  = wb_jal ? DW'(wb_pc) : wb_data;

    assign grant_fifo = stall_req || (!pipe_req && non_empty);
    assign grant_pipe = pipe_req && !stall_req;
    assign push       = lu_valid && lu_ready;

    assign head_addr  = q_addr[rd_ptr];
    assign head_data  = q_data[rd_ptr];
    assign head_kill  = q_kill[rd_ptr];

    // Older queued results to the same register are superseded by a granted pipeline write.
    always_comb begin
        kill_hit = '0;
        offset   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset      = PW'(i) - rd_ptr;
            kill_hit[i] = grant_pipe && ({1'b0, offset} < count) && (q_addr[i] == pipe_addr);
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
            end
            q_kill <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            q_kill <= q_kill | kill_hit;
            if (push) begin
                q_addr[wr_ptr] <= lu_addr;
                q_data[wr_ptr] <= lu_data;
                q_kill[wr_ptr] <= 1'b0;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (grant_fifo) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, grant_fifo})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head-of-queue age; saturates so stall_req holds until the head pops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!non_empty || grant_fifo) begin
            wait_cnt <= '0;
        end else if (wait_cnt != 4'(STARVE_LIMIT)) begin
            wait_cnt <= wait_cnt + 4'(1);
        end
    end

    // Registered write port; register 0 and killed entries consume the slot without writing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (grant_fifo) begin
            rf_wen   <= !head_kill && (head_addr != '0);
            rf_waddr <= head_addr;
            rf_wdata <= head_data;
        end else if (grant_pipe) begin
            rf_wen   <= (pipe_addr != '0);
            rf_waddr <= pipe_addr;
            rf_wdata <= pipe_data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

`ifdef WB_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lu_writes <= '0;
            stat_stalls    <= '0;
            stat_kills     <= '0;
        end else begin
            if (grant_fifo && !head_kill && (head_addr != '0) && (stat_lu_writes != 16'hFFFF))
                stat_lu_writes <= stat_lu_writes + 16'd1;
            if (stall_req && (stat_stalls != 16'hFFFF))
                stat_stalls <= stat_stalls + 16'd1;
            if (grant_fifo && head_kill && (stat_kills != 16'hFFFF))
                stat_kills <= stat_kills + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed vector table, reset-mid-drain sequence,
// and randomized traffic against a queue-based reference model.
`ifndef ASIZE
`define ASIZE 5
`endif
`ifndef DSIZE
`define DSIZE 32
`endif
`ifndef ISIZE
`define ISIZE 32
`endif

module tb_rf_write_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
    localparam int LINK  = 31;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_wen, wb_jal, lu_valid;
    logic [4:0]  wb_addr, lu_addr;
    logic [31:0] wb_data, wb_pc, lu_data;
    logic        lu_ready, stall_req, rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef WB_ARB_STATS_EN
    logic [15:0] stat_lu_writes, stat_stalls, stat_kills;
`endif

    rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .LINK_REG(LINK)) dut (
        .clk(clk), .rst(rst),
        .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_jal(wb_jal), .wb_pc(wb_pc),
        .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data),
        .lu_ready(lu_ready), .stall_req(stall_req),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef WB_ARB_STATS_EN
        , .stat_lu_writes(stat_lu_writes), .stat_stalls(stat_stalls), .stat_kills(stat_kills)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        wen;  logic [4:0] waddr; logic [31:0] wdata;
        logic        jal;  logic [31:0] pc;
        logic        lv;   logic [4:0] laddr; logic [31:0] ldata;
        logic        e_ready; logic e_stall;
        logic        e_wen;   logic chk_ad; logic [4:0] e_addr; logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                                input logic jal, input logic [31:0] pc,
                                input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                input logic er, input logic es, input logic ew, input logic ca,
                                input logic [4:0] ea, input logic [31:0] ed);
        vec_t v;
        v.wen = wen; v.waddr = wa; v.wdata = wd; v.jal = jal; v.pc = pc;
        v.lv = lv; v.laddr = la; v.ldata = ld;
        v.e_ready = er; v.e_stall = es; v.e_wen = ew; v.chk_ad = ca; v.e_addr = ea; v.e_data = ed;
        return v;
    endfunction

    // Reference model: queue of pending results, age of the head in cycles.
    typedef struct { logic [4:0] addr; logic [31:0] data; logic kill; } ent_t;
    ent_t m_q[$];
    int   m_age;
    logic m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic model_reset();
        m_q.delete();
        m_age = 0;
        m_wen = 1'b0; m_addr = '0; m_data = '0;
    endtask

    function automatic logic m_stall();
        return (m_q.size() != 0) && (m_age == LIMIT);
    endfunction

    function automatic logic m_ready();
        return m_q.size() < DEPTH;
    endfunction

    task automatic model_cycle();
        logic        st, rdy, preq, popped, was_empty;
        logic [4:0]  pa;
        logic [31:0] pd;
        ent_t        h, n;
        st        = m_stall();
        rdy       = m_ready();
        was_empty = (m_q.size() == 0);
        preq      = wb_wen || wb_jal;
        pa        = wb_jal ? 5'(LINK) : wb_addr;
        pd        = wb_jal ? wb_pc : wb_data;
        popped    = 1'b0;
        if (st || (!preq && !was_empty)) begin
            h = m_q.pop_front();
            popped = 1'b1;
            m_wen = !h.kill && (h.addr != 0); m_addr = h.addr; m_data = h.data;
        end else if (preq) begin
            m_wen = (pa != 0); m_addr = pa; m_data = pd;
            foreach (m_q[i]) if (m_q[i].addr == pa) m_q[i].kill = 1'b1;
        end else begin
            m_wen = 1'b0;
        end
        if (lu_valid && rdy) begin
            n.addr = lu_addr; n.data = lu_data; n.kill = 1'b0;
            m_q.push_back(n);
        end
        if (was_empty || popped) m_age = 0;
        else if (m_age < LIMIT) m_age++;
    endtask

    task automatic idle_inputs();
        wb_wen = 0; wb_addr = 0; wb_data = 0; wb_jal = 0; wb_pc = 0;
        lu_valid = 0; lu_addr = 0; lu_data = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        vec_t v;
        rst = 1'b0;
        idle_inputs();

        // Directed table (DEPTH=2, STARVE_LIMIT=4).
        //           wen wa  wd       jal pc     lv la  ld        rdy st  wen ca ea  ed
        vecs.push_back(mk(1, 5, 32'h1234, 0, 0,     0, 0,  0,        1, 0, 1, 1, 5,  32'h1234));
        vecs.push_back(mk(0, 7, 0,        1, 32'h40,0, 0,  0,        1, 0, 1, 1, 31, 32'h40));
        vecs.push_back(mk(0, 0, 0,        0, 0,     1, 3,  32'hAA,   1, 0, 0, 1, 31, 32'h40));
        vecs.push_back(mk(0, 0, 0,        0, 0,     0, 0,  0,        1, 0, 1, 1, 3,  32'hAA));
        vecs.push_back(mk(0, 0, 0,        0, 0,     1, 0,  32'h55,   1, 0, 0, 1, 3,  32'hAA));
        vecs.push_back(mk(0, 0, 0,        0, 0,     0, 0,  0,        1, 0, 0, 0, 0,  0));
        vecs.push_back(mk(1, 10,1,        0, 0,     1, 20, 32'hB1,   1, 0, 1, 1, 10, 1));
        vecs.push_back(mk(1, 11,2,        0, 0,     1, 21, 32'hB2,   1, 0, 1, 1, 11, 2));
        vecs.push_back(mk(1, 12,3,        0, 0,     0, 0,  0,        0, 0, 1, 1, 12, 3));
        vecs.push_back(mk(1, 13,4,        0, 0,     0, 0,  0,        0, 0, 1, 1, 13, 4));
        vecs.push_back(mk(1, 14,5,        0, 0,     0, 0,  0,        0, 0, 1, 1, 14, 5));
        vecs.push_back(mk(1, 15,6,        0, 0,     0, 0,  0,        0, 1, 1, 1, 20, 32'hB1));
        vecs.push_back(mk(1, 16,7,        0, 0,     0, 0,  0,        1, 0, 1, 1, 16, 7));
        vecs.push_back(mk(0, 0, 0,        0, 0,     0, 0,  0,        1, 0, 1, 1, 21, 32'hB2));
        vecs.push_back(mk(0, 0, 0,        0, 0,     1, 9,  32'h11,   1, 0, 0, 1, 21, 32'hB2));
        vecs.push_back(mk(1, 9, 32'h22,   0, 0,     0, 0,  0,        1, 0, 1, 1, 9,  32'h22));
        vecs.push_back(mk(0, 0, 0,        0, 0,     0, 0,  0,        1, 0, 0, 0, 0,  0));
        vecs.push_back(mk(1, 9, 32'h33,   0, 0,     1, 9,  32'h44,   1, 0, 1, 1, 9,  32'h33));
        vecs.push_back(mk(0, 0, 0,        0, 0,     0, 0,  0,        1, 0, 1, 1, 9,  32'h44));

        // Reset asserted mid-cycle: outputs clear immediately.
        #2 rst = 1'b1;
        #1;
        chk("reset_rf_wen",   32'(rf_wen),   32'd0);
        chk("reset_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("reset_rf_wdata", rf_wdata,      32'd0);
        chk("reset_lu_ready", 32'(lu_ready), 32'd1);
        chk("reset_stall",    32'(stall_req),32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[k]) begin
            v = vecs[k];
            wb_wen = v.wen; wb_addr = v.waddr; wb_data = v.wdata; wb_jal = v.jal; wb_pc = v.pc;
            lu_valid = v.lv; lu_addr = v.laddr; lu_data = v.ldata;
            #1;
            chk($sformatf("vec%0d_lu_ready", k), 32'(lu_ready),  32'(v.e_ready));
            chk($sformatf("vec%0d_stall",    k), 32'(stall_req), 32'(v.e_stall));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_rf_wen", k), 32'(rf_wen), 32'(v.e_wen));
            if (v.chk_ad) begin
                chk($sformatf("vec%0d_rf_waddr", k), 32'(rf_waddr), 32'(v.e_addr));
                chk($sformatf("vec%0d_rf_wdata", k), rf_wdata,      v.e_data);
            end
        end
        idle_inputs();
`ifdef WB_ARB_STATS_EN
        chk("stat_kills",     32'(stat_kills),     32'd1);
        chk("stat_stalls",    32'(stat_stalls),    32'd1);
        chk("stat_lu_writes", 32'(stat_lu_writes), 32'd4);
`endif

        // Reset mid-drain discards queued results.
        lu_valid = 1; lu_addr = 6; lu_data = 32'h66;
        @(posedge clk); #1;
        lu_addr = 8; lu_data = 32'h88;
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("middrain_lu_ready", 32'(lu_ready), 32'd1);
        chk("middrain_rf_wen",   32'(rf_wen),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("middrain_no_write", 32'(rf_wen), 32'd0);
        @(posedge clk); #1;
        chk("middrain_no_write2", 32'(rf_wen), 32'd0);

        // Randomized traffic against the reference model.
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            wb_wen   = ($urandom_range(0, 9) < 4);
            wb_jal   = ($urandom_range(0, 9) == 0);
            wb_addr  = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            wb_pc    = $urandom;
            lu_valid = ($urandom_range(0, 1) == 1);
            lu_addr  = 5'($urandom_range(0, 7));
            lu_data  = $urandom;
            if (c % 8 == 0) lu_addr = 5'(LINK);
            #1;
            chk("rand_lu_ready", 32'(lu_ready),  32'(m_ready()));
            chk("rand_stall",    32'(stall_req), 32'(m_stall()));
            model_cycle();
            @(posedge clk); #1;
            chk("rand_rf_wen", 32'(rf_wen), 32'(m_wen));
            if (m_wen) begin
                chk("rand_rf_waddr", 32'(rf_waddr), 32'(m_addr));
                chk("rand_rf_wdata", rf_wdata,      m_data);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single register-file write port and shares it between the in-order pipeline writeback (wb_*) and a long-latency functional unit (lu_*, e.g. the multi-cycle mul/div).
- Pipeline writes have priority. Long-unit results wait in a small FIFO and drain on idle write slots.
- A starvation guard freezes the pipeline for one cycle when a queued result has waited too long.
- Sits between the writeback pipeline register and the register file; performs JAL link writes.

Parameters:
- DEPTH, 2: long-unit result FIFO entries; power of two, 2..8.
- STARVE_LIMIT, 4: cycles a FIFO head may wait before stall_req asserts; range 1..15.
- LINK_REG, 31: register address written by JAL.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_wen  in  1  pipeline writeback write enable.
- wb_addr  in  `ASIZE  pipeline destination register.
- wb_data  in  `DSIZE  pipeline write data.
- wb_jal  in  1  writeback is a JAL link write.
- wb_pc  in  `ISIZE  return address supplied with JAL.
- lu_valid  in  1  long-unit result valid.
- lu_addr  in  `ASIZE  long-unit destination register.
- lu_data  in  `DSIZE  long-unit result.
- lu_ready  out  1  FIFO can accept; equals not full. Combinational from state only.
- stall_req  out  1  pipeline must freeze and hold wb_* stable this cycle.
- rf_wen  out  1  register-file write enable, registered.
- rf_waddr  out  `ASIZE  register-file write address, registered.
- rf_wdata  out  `DSIZE  register-file write data, registered.

Behaviour:
- Reset is asynchronous and active-high. It clears rf_wen, rf_waddr, rf_wdata, the FIFO pointers/count, the kill bits and wait_cnt. After reset: lu_ready=1, stall_req=0. Reset mid-drain discards all queued results.
- Pipeline request:
  - Present when wb_wen=1 or wb_jal=1.
  - JAL overrides: address=LINK_REG, data=wb_pc zero-extended or truncated to `DSIZE.
  - Otherwise address=wb_addr, data=wb_data.
- Long-unit enqueue: a handshake occurs when lu_valid=1 and lu_ready=1. The entry is pushed with kill=0. lu_valid held while lu_ready=0 must keep lu_addr/lu_data stable.
- Grant, evaluated each cycle:
  - stall_req=1: grant FIFO head and ignore the pipeline request.
  - else pipeline request present: grant pipeline.
  - else FIFO non-empty: grant FIFO head.
  - else no write.
- Output latency is 1 cycle. The granted write is registered onto rf_* at the next edge. With no grant, rf_wen=0 and rf_waddr/rf_wdata hold their previous values.
- Zero register: any granted write to address 0 yields rf_wen=0, but the grant still consumes the slot/pops the entry.
- Killed entries: a granted FIFO head with kill=1 is popped with rf_wen=0.
- Write-after-write ordering: when a pipeline write is granted to address A, every valid FIFO entry with addr==A gets kill=1. The pipeline instruction is younger, so its value wins.
- Same-cycle enqueue of A with a pipeline write to A: the new entry is not killed, because the long-unit result is younger.
- Simultaneous push and pop: both happen and the count is unchanged. Full with simultaneous pop: lu_ready stays 0 this cycle, since it is computed from registered state.
- Starvation counter wait_cnt:
  - Clears when the FIFO is empty or the head pops.
  - Otherwise increments, saturating at STARVE_LIMIT.
  - stall_req = FIFO non-empty AND wait_cnt==STARVE_LIMIT. It is combinational from registered state and lasts exactly one cycle per starvation event, because the head pops that cycle.
- Pointers wrap modulo DEPTH. The count is held in an extra bit to distinguish full from empty.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- When defined, three 16-bit saturating counters are added: stat_lu_writes (FIFO entries committed with rf_wen=1), stat_stalls (cycles with stall_req=1) and stat_kills (entries popped as killed). They are exposed on extra output ports stat_lu_writes, stat_stalls and stat_kills, and cleared by rst.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset and plain writeback: assert rst mid-cycle, then wb_wen=1, wb_addr=5, wb_data=0x1234 → one cycle later rf_wen=1, rf_waddr=5, rf_wdata=0x1234. rf_* are 0 and lu_ready=1 immediately on rst.
- JAL: wb_jal=1, wb_pc=0x40, wb_addr=7 → rf_waddr=31, rf_wdata=0x40.
- Idle drain: pipeline idle, lu_valid=1 with addr=3, data=0xAA → FIFO drains at the next edge, and rf_* show addr 3/0xAA one cycle after the grant. Addr 0 entry → rf_wen stays 0.
- Full FIFO and starvation: pipeline writes every cycle, push 2 results → lu_ready=0 after second push. stall_req=1 exactly STARVE_LIMIT=4 cycles after first push, head written, wb_* ignored that cycle.
- Kill: enqueue addr=9 data=0x11, then pipeline writes addr 9 data=0x22 before drain → only 0x22 reaches r9, entry popped with rf_wen=0. Same-cycle enqueue of addr 9 with pipeline write to addr 9 → entry survives and writes later.
- With WB_ARB_STATS_EN: after the kill and starvation scenarios, stat_kills=1 and stat_stalls=1.
